// File: rtl/seq_decoder_if.sv
// Handshake/bus bundle for seq_decoder: decode controls in, one-hot strobe and scan status out.
// The dwell field exists only when SEQ_DECODER_PRESCALE_EN is defined.
interface seq_decoder_if #(
    parameter int IN_W = 3
`ifdef SEQ_DECODER_PRESCALE_EN
    ,
    parameter int DWELL_W = 4
`endif
);
    localparam int OUT_W = 2**IN_W;

    logic              en;
    logic              mode;
    logic              start;
    logic [IN_W-1:0]   in_code;
`ifdef SEQ_DECODER_PRESCALE_EN
    logic [DWELL_W-1:0] dwell;
`endif
    logic [OUT_W-1:0]  out;
    logic [IN_W-1:0]   code_out;
    logic              valid;
    logic              busy;
    logic              done;

    modport master (
        output en, mode, start, in_code,
`ifdef SEQ_DECODER_PRESCALE_EN
        output dwell,
`endif
        input  out, code_out, valid, busy, done
    );

    modport slave (
        input  en, mode, start, in_code,
`ifdef SEQ_DECODER_PRESCALE_EN
        input  dwell,
`endif
        output out, code_out, valid, busy, done
    );
endinterface

// File: rtl/seq_decoder.sv
// Binary-to-one-hot decoder with registered outputs and an automatic code-scan sequencer.
// SEQ_DECODER_PRESCALE_EN adds a per-code dwell down-counter loaded from the dwell input.
module seq_decoder #(
    parameter int IN_W    = 3,
    parameter int DWELL_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_decoder_if.slave bus
);
    // state | meaning
    // IDLE  | direct decode (mode=0) or waiting for an accepted scan start (mode=1)
    // SCAN  | stepping codes 0..OUT_W-1; en=0 pauses with out/valid blanked

    localparam int OUT_W = 2**IN_W;
    localparam logic [IN_W-1:0]  CODE_LAST = IN_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] HOT_ZERO  = OUT_W'(1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   out_q, out_nxt;
    logic [IN_W-1:0]    code_q, code_nxt;
    logic               valid_q, valid_nxt;
    logic               done_q, done_nxt;
    logic               paused_q, paused_nxt;
    logic [DWELL_W-1:0] cnt_q;
    logic               cnt_zero;

`ifdef SEQ_DECODER_PRESCALE_EN
    logic [DWELL_W-1:0] cnt_nxt;
    logic [DWELL_W-1:0] cap_q, cap_nxt;
`else
    // Without the prescaler every code sits at terminal count immediately.
    assign cnt_q = '0;
`endif

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_q    <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            paused_q <= 1'b0;
`ifdef SEQ_DECODER_PRESCALE_EN
            cnt_q    <= '0;
            cap_q    <= '0;
`endif
        end else begin
            state    <= state_nxt;
            out_q    <= out_nxt;
            code_q   <= code_nxt;
            valid_q  <= valid_nxt;
            done_q   <= done_nxt;
            paused_q <= paused_nxt;
`ifdef SEQ_DECODER_PRESCALE_EN
            cnt_q    <= cnt_nxt;
            cap_q    <= cap_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        out_nxt    = out_q;
        code_nxt   = code_q;
        valid_nxt  = valid_q;
        done_nxt   = 1'b0;
        paused_nxt = paused_q;
`ifdef SEQ_DECODER_PRESCALE_EN
        cnt_nxt    = cnt_q;
        cap_nxt    = cap_q;
`endif
        case (state)
            IDLE: begin
                paused_nxt = 1'b0;
                if (!bus.mode) begin
                    out_nxt   = bus.en ? (HOT_ZERO << bus.in_code) : '0;
                    code_nxt  = bus.in_code;
                    valid_nxt = bus.en;
                end else if (bus.start && bus.en) begin
                    out_nxt   = HOT_ZERO;
                    code_nxt  = '0;
                    valid_nxt = 1'b1;
                    state_nxt = SCAN;
`ifdef SEQ_DECODER_PRESCALE_EN
                    cap_nxt   = bus.dwell;
                    cnt_nxt   = bus.dwell;
`endif
                end else begin
                    out_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            SCAN: begin
                if (!bus.en) begin
                    out_nxt    = '0;
                    valid_nxt  = 1'b0;
                    paused_nxt = 1'b1;
                end else if (paused_q) begin
                    // Resume edge only restores the strobe; dwell resumes on the following edge.
                    out_nxt    = HOT_ZERO << code_q;
                    valid_nxt  = 1'b1;
                    paused_nxt = 1'b0;
                end else if (!cnt_zero) begin
`ifdef SEQ_DECODER_PRESCALE_EN
                    cnt_nxt = cnt_q - 1'b1;
`endif
                end else if (code_q != CODE_LAST) begin
                    code_nxt = code_q + 1'b1;
                    out_nxt  = out_q << 1;
`ifdef SEQ_DECODER_PRESCALE_EN
                    cnt_nxt  = cap_q;
`endif
                end else begin
                    out_nxt   = '0;
                    valid_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out      = out_q;
    assign bus.code_out = code_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = (state == SCAN);
    assign bus.done     = done_q;
endmodule
